// File: rtl/controle_movimento_elevador_pkg.sv
// Shared types and constants for the elevator motion controller.
// State encoding, floor count/index width and direction constants.
package pkg_elevador;

  localparam int N_ANDARES  = 4;
  localparam int LARG_ANDAR = $clog2(N_ANDARES);

  localparam logic SUBIR  = 1'b1;
  localparam logic DESCER = 1'b0;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    MOVENDO = 2'd1,
    PORTA   = 2'd2
  } estado_t;

endpackage

// File: rtl/controle_movimento_elevador_temporizador.sv
// Tick-enabled counter used for both travel and door timing.
// Counts 0..LIMITE-1; fim_o flags the tick that completes the interval.
module temporizador_ticks #(
  parameter int LIMITE = 2,
  localparam int W = (LIMITE > 1) ? $clog2(LIMITE) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tick_i,
  input  logic         limpa_i,
  input  logic         segura_i,
  output logic [W-1:0] contagem_o,
  output logic         fim_o
);

  localparam logic [W-1:0] ULTIMO = W'(LIMITE - 1);
  localparam logic [W-1:0] UM     = W'(1);

  logic [W-1:0] cont_q;
  logic [W-1:0] cont_d;

  assign contagem_o = cont_q;
  assign fim_o      = tick_i & ~segura_i & (cont_q == ULTIMO);

  // Next count: clear wins; while held the count parks on its last value.
  always_comb begin
    cont_d = cont_q;
    if (limpa_i) begin
      cont_d = '0;
    end else if (tick_i) begin
      if (cont_q == ULTIMO) begin
        cont_d = segura_i ? cont_q : '0;
      end else begin
        cont_d = cont_q + UM;
      end
    end else begin
      cont_d = cont_q;
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

endmodule

// File: rtl/controle_movimento_elevador.sv
// Elevator call scheduler and motion FSM (SCAN policy, door dwell, overload hold).
// Drives the floor index shown on the 7-segment display plus status flags.
module controle_movimento_elevador
  import pkg_elevador::*;
#(
  parameter int TICKS_POR_ANDAR = 2,
  parameter int TICKS_PORTA     = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [N_ANDARES-1:0]  req_andar,
  input  logic                  sobrecarga,
  output logic [LARG_ANDAR-1:0] andar_atual,
  output logic                  porta_aberta,
  output logic                  movendo,
  output logic                  direcao,
  output logic [N_ANDARES-1:0]  pedidos
);

  localparam logic [LARG_ANDAR-1:0] TOPO  = LARG_ANDAR'(N_ANDARES - 1);
  localparam logic [LARG_ANDAR-1:0] TERREO = '0;
  localparam logic [LARG_ANDAR-1:0] UM    = LARG_ANDAR'(1);

  estado_t               estado_q, estado_d;
  logic [LARG_ANDAR-1:0] andar_q, andar_d;
  logic                  direcao_q, direcao_d;
  logic [N_ANDARES-1:0]  pedidos_q, pedidos_d;
  logic                  porta_q, movendo_q;

  logic [N_ANDARES-1:0]  pend_s, limpa_s;
  logic                  dir_s, reinicia_s;
  logic                  fim_viagem_s, fim_porta_s;

  function automatic logic a_frente(input logic [N_ANDARES-1:0] p,
                                     input logic [LARG_ANDAR-1:0] a,
                                     input logic d);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_ANDARES; i++) begin
      if (d == SUBIR ? (i > int'(a)) : (i < int'(a))) r = r | p[i];
    end
    return r;
  endfunction

  temporizador_ticks #(.LIMITE(TICKS_POR_ANDAR)) u_tempo_viagem (
    .clock(clock), .reset(reset), .tick_i(tick),
    .limpa_i(estado_q != MOVENDO), .segura_i(1'b0),
    .contagem_o(), .fim_o(fim_viagem_s)
  );

  temporizador_ticks #(.LIMITE(TICKS_PORTA)) u_tempo_porta (
    .clock(clock), .reset(reset), .tick_i(tick),
    .limpa_i((estado_q != PORTA) | reinicia_s), .segura_i(sobrecarga),
    .contagem_o(), .fim_o(fim_porta_s)
  );

  // Next-state logic; fresh calls are visible in the same cycle they arrive.
  always_comb begin
    estado_d   = estado_q;
    andar_d    = andar_q;
    direcao_d  = direcao_q;
    dir_s      = direcao_q;
    reinicia_s = 1'b0;
    pend_s     = pedidos_q | req_andar;
    case (estado_q)
      OCIOSO: begin
        if (pend_s == '0) begin
          estado_d = OCIOSO;
        end else if (pend_s[andar_q]) begin
          estado_d = PORTA;
        end else begin
          if (andar_q == TERREO) begin
            dir_s = SUBIR;
          end else if (andar_q == TOPO) begin
            dir_s = DESCER;
          end else begin
            dir_s = a_frente(pend_s, andar_q, direcao_q) ? direcao_q : ~direcao_q;
          end
          direcao_d = dir_s;
          estado_d  = sobrecarga ? OCIOSO : MOVENDO;
        end
      end
      MOVENDO: begin
        if (fim_viagem_s) begin
          if (direcao_q == SUBIR && andar_q != TOPO) begin
            andar_d = andar_q + UM;
          end else if (direcao_q == DESCER && andar_q != TERREO) begin
            andar_d = andar_q - UM;
          end else begin
            andar_d = andar_q;
          end
          if (pend_s[andar_d]) begin
            estado_d = PORTA;
          end else begin
            estado_d = a_frente(pend_s, andar_d, direcao_q) ? MOVENDO : OCIOSO;
          end
        end else begin
          estado_d = MOVENDO;
        end
      end
      PORTA: begin
        if (req_andar[andar_q]) begin
          reinicia_s = 1'b1;
        end else if (fim_porta_s) begin
          estado_d = OCIOSO;
        end else begin
          estado_d = PORTA;
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // The floor being served drops its call; a coincident new press is absorbed.
  always_comb begin
    limpa_s = '0;
    if (estado_d == PORTA) begin
      limpa_s[andar_d] = 1'b1;
    end else begin
      limpa_s = '0;
    end
    pedidos_d = pend_s & ~limpa_s;
  end

  // State and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      andar_q   <= '0;
      direcao_q <= SUBIR;
      pedidos_q <= '0;
      porta_q   <= 1'b0;
      movendo_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      andar_q   <= andar_d;
      direcao_q <= direcao_d;
      pedidos_q <= pedidos_d;
      porta_q   <= (estado_d == PORTA);
      movendo_q <= (estado_d == MOVENDO);
    end
  end

  assign andar_atual  = andar_q;
  assign porta_aberta = porta_q;
  assign movendo      = movendo_q;
  assign direcao      = direcao_q;
  assign pedidos      = pedidos_q;

endmodule

// File: tb/tb_controle_movimento_elevador.sv
// Directed bench: one task per scenario, observing {andar, porta, movendo, direcao, pedidos}.
module tb_controle_movimento_elevador;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] req_andar = 4'b0000;
  logic       sobrecarga = 1'b0;
  logic [1:0] andar_atual;
  logic       porta_aberta, movendo, direcao;
  logic [3:0] pedidos;
  logic [8:0] obs, esp;
  int         n_checks = 0;
  int         n_fail = 0;

  assign obs = {andar_atual, porta_aberta, movendo, direcao, pedidos};

  controle_movimento_elevador dut (
    .clock(clock), .reset(reset), .tick(tick), .req_andar(req_andar),
    .sobrecarga(sobrecarga), .andar_atual(andar_atual), .porta_aberta(porta_aberta),
    .movendo(movendo), .direcao(direcao), .pedidos(pedidos)
  );

  always #5 clock = ~clock;

  task automatic clk1(input logic [3:0] r, input logic t);
    req_andar = r; tick = t;
    @(posedge clock); #1;
    req_andar = 4'b0000; tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      clk1(4'b0000, 1'b0); clk1(4'b0000, 1'b0); clk1(4'b0000, 1'b0); clk1(4'b0000, 1'b1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; sobrecarga = 1'b0;
    clk1(4'b0000, 1'b0); clk1(4'b0000, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    esp = {2'd0, 1'b0, 1'b0, 1'b1, 4'b0000};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL reset_state got=%b exp=%b", obs, esp); end
    ticks(5);
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL idle_no_req got=%b exp=%b", obs, esp); end
  endtask

  task automatic test_single_call();
    do_reset();
    clk1(4'b1000, 1'b0);
    esp = {2'd0, 1'b0, 1'b1, 1'b1, 4'b1000};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL up_depart got=%b exp=%b", obs, esp); end
    ticks(1);
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL up_one_tick got=%b exp=%b", obs, esp); end
    ticks(1);
    esp = {2'd1, 1'b0, 1'b1, 1'b1, 4'b1000};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL up_floor1 got=%b exp=%b", obs, esp); end
    ticks(4);
    esp = {2'd3, 1'b1, 1'b0, 1'b1, 4'b0000};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL up_arrive3 got=%b exp=%b", obs, esp); end
    ticks(2);
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL up_door_dwell got=%b exp=%b", obs, esp); end
    ticks(1);
    esp = {2'd3, 1'b0, 1'b0, 1'b1, 4'b0000};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL up_door_close got=%b exp=%b", obs, esp); end
  endtask

  task automatic test_scan();
    do_reset();
    clk1(4'b1010, 1'b0);
    clk1(4'b0001, 1'b0);
    esp = {2'd0, 1'b0, 1'b1, 1'b1, 4'b1011};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL scan_latch got=%b exp=%b", obs, esp); end
    ticks(2);
    esp = {2'd1, 1'b1, 1'b0, 1'b1, 4'b1001};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL scan_stop1 got=%b exp=%b", obs, esp); end
    ticks(3);
    esp = {2'd1, 1'b0, 1'b0, 1'b1, 4'b1001};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL scan_close1 got=%b exp=%b", obs, esp); end
    ticks(2);
    esp = {2'd2, 1'b0, 1'b1, 1'b1, 4'b1001};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL scan_pass2 got=%b exp=%b", obs, esp); end
    ticks(2);
    esp = {2'd3, 1'b1, 1'b0, 1'b1, 4'b0001};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL scan_stop3 got=%b exp=%b", obs, esp); end
    ticks(3);
    ticks(2);
    esp = {2'd2, 1'b0, 1'b1, 1'b0, 4'b0001};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL scan_reverse got=%b exp=%b", obs, esp); end
    ticks(4);
    esp = {2'd0, 1'b1, 1'b0, 1'b0, 4'b0000};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL scan_stop0 got=%b exp=%b", obs, esp); end
  endtask

  task automatic test_overload_door();
    do_reset();
    clk1(4'b0100, 1'b0);
    ticks(4);
    esp = {2'd2, 1'b1, 1'b0, 1'b1, 4'b0000};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL ovl_arrive2 got=%b exp=%b", obs, esp); end
    sobrecarga = 1'b1;
    clk1(4'b0001, 1'b0);
    ticks(10);
    esp = {2'd2, 1'b1, 1'b0, 1'b1, 4'b0001};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL ovl_door_held got=%b exp=%b", obs, esp); end
    sobrecarga = 1'b0;
    ticks(1);
    esp = {2'd2, 1'b0, 1'b0, 1'b1, 4'b0001};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL ovl_close got=%b exp=%b", obs, esp); end
    clk1(4'b0000, 1'b0);
    esp = {2'd2, 1'b0, 1'b1, 1'b0, 4'b0001};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL ovl_descend got=%b exp=%b", obs, esp); end
    ticks(4);
    esp = {2'd0, 1'b1, 1'b0, 1'b0, 4'b0000};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL ovl_reach0 got=%b exp=%b", obs, esp); end
  endtask

  task automatic test_overload_departure();
    do_reset();
    sobrecarga = 1'b1;
    clk1(4'b0010, 1'b0);
    ticks(2);
    esp = {2'd0, 1'b0, 1'b0, 1'b1, 4'b0010};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL ovl_no_depart got=%b exp=%b", obs, esp); end
    sobrecarga = 1'b0;
    clk1(4'b0000, 1'b0);
    ticks(1);
    esp = {2'd0, 1'b0, 1'b1, 1'b1, 4'b0010};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL ovl_departed got=%b exp=%b", obs, esp); end
    sobrecarga = 1'b1;
    ticks(1);
    esp = {2'd1, 1'b1, 1'b0, 1'b1, 4'b0000};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL ovl_midtravel got=%b exp=%b", obs, esp); end
    sobrecarga = 1'b0;
    ticks(3);
    esp = {2'd1, 1'b0, 1'b0, 1'b1, 4'b0000};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL ovl_close1 got=%b exp=%b", obs, esp); end
  endtask

  task automatic test_reset_and_clear();
    do_reset();
    clk1(4'b1000, 1'b0);
    ticks(5);
    esp = {2'd2, 1'b0, 1'b1, 1'b1, 4'b1000};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL mid_travel got=%b exp=%b", obs, esp); end
    reset = 1'b1;
    clk1(4'b0000, 1'b0);
    reset = 1'b0;
    esp = {2'd0, 1'b0, 1'b0, 1'b1, 4'b0000};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL reset_midtravel got=%b exp=%b", obs, esp); end
    clk1(4'b0001, 1'b0);
    esp = {2'd0, 1'b1, 1'b0, 1'b1, 4'b0000};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL clear_wins got=%b exp=%b", obs, esp); end
    ticks(2);
    clk1(4'b0001, 1'b0);
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL door_restart got=%b exp=%b", obs, esp); end
    ticks(2);
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL door_extended got=%b exp=%b", obs, esp); end
    ticks(1);
    esp = {2'd0, 1'b0, 1'b0, 1'b1, 4'b0000};
    n_checks++; if (obs !== esp) begin n_fail++; $display("FAIL door_close_after got=%b exp=%b", obs, esp); end
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_scan();
    test_overload_door();
    test_overload_departure();
    test_reset_and_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
